// File: rtl/seq1010_frame_tx.sv
// Serial frame transmitter for the 1010 sync-word link.
// A frame is SYNC(1010), the payload MSB first with a stuffed '1' after every
// "101" run (when STUFF_EN), and a single '1' stop bit. The idle line is 1.
// The state register always describes the bit currently driven on sout.
// Handshake: a word is taken on the rising edge where tx_valid && tx_ready;
// tx_ready depends only on state, tx_data must be stable while tx_valid is
// high, and tx_valid while tx_ready=0 is simply held off (never dropped).
module seq1010_frame_tx #(
  parameter int DATA_W   = 8,
  parameter bit STUFF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              stuff,
  output logic [2:0]        dbg_state
);

  localparam logic [3:0] SYNC_WORD = 4'b1010;
  localparam int         CNT_W     = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_DATA   = 3'd2,
    S_STUFFB = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sout_q, sout_d;
  logic              stuff_q, stuff_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        sync_idx_q, sync_idx_d;
  logic [2:0]        hist_q, hist_d;

  logic       accept;
  logic       load;
  logic       place;
  logic [2:0] hist_base;
  logic [1:0] sync_nxt;

  assign tx_ready  = (state_q == S_IDLE) || (state_q == S_STOP);
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != S_IDLE);
  assign sout      = sout_q;
  assign stuff     = stuff_q;
  assign dbg_state = state_q;
  assign sync_nxt  = sync_idx_q - 2'd1;

  // Next-state and next-bit selection; load/place are shared actions.
  always_comb begin
    state_d    = state_q;
    sout_d     = 1'b1;
    stuff_d    = 1'b0;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sync_idx_d = sync_idx_q;
    hist_d     = hist_q;
    load       = 1'b0;
    place      = 1'b0;
    hist_base  = hist_q;

    case (state_q)
      S_IDLE: begin
        if (accept) load = 1'b1;
      end
      S_SYNC: begin
        if (sync_idx_q == 2'd0) begin
          // Sync tail "010" seeds the history so stuffing sees across the boundary.
          hist_base = SYNC_WORD[2:0];
          place     = 1'b1;
          state_d   = S_DATA;
        end else begin
          sout_d     = SYNC_WORD[sync_nxt];
          sync_idx_d = sync_nxt;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = S_STOP;
        end else if (STUFF_EN && (hist_q == 3'b101)) begin
          stuff_d = 1'b1;
          hist_d  = 3'b011;
          state_d = S_STUFFB;
        end else begin
          place = 1'b1;
        end
      end
      S_STUFFB: begin
        place   = 1'b1;
        state_d = S_DATA;
      end
      S_STOP: begin
        if (accept) load = 1'b1;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d    = tx_data;
      cnt_d      = '0;
      sync_idx_d = 2'd3;
      hist_d     = 3'b000;
      sout_d     = SYNC_WORD[3];
      state_d    = S_SYNC;
    end

    if (place) begin
      sout_d  = shift_q[DATA_W-1];
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      hist_d  = {hist_base[1:0], shift_q[DATA_W-1]};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sout_q     <= 1'b1;
      stuff_q    <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      sync_idx_q <= 2'd0;
      hist_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      sout_q     <= sout_d;
      stuff_q    <= stuff_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sync_idx_q <= sync_idx_d;
      hist_q     <= hist_d;
    end
  end

endmodule

// File: tb/tb_seq1010_frame_tx.sv
// Bench for seq1010_frame_tx: one instance with stuffing, one without.
module tb_seq1010_frame_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         tb_valid;
  logic         use1;
  logic [W-1:0] tx_data;

  logic       tx_valid1, ready1, sout1, busy1, stuff1;
  logic       tx_valid0, ready0, sout0, busy0, stuff0;
  logic [2:0] dbg1, dbg0;
  logic       o_sout, o_stuff, o_ready, o_busy;

  assign tx_valid1 = tb_valid & use1;
  assign tx_valid0 = tb_valid & ~use1;
  assign o_sout    = use1 ? sout1  : sout0;
  assign o_stuff   = use1 ? stuff1 : stuff0;
  assign o_ready   = use1 ? ready1 : ready0;
  assign o_busy    = use1 ? busy1  : busy0;

  seq1010_frame_tx #(.DATA_W(W), .STUFF_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(ready1), .sout(sout1), .busy(busy1), .stuff(stuff1),
    .dbg_state(dbg1)
  );

  seq1010_frame_tx #(.DATA_W(W), .STUFF_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_ready(ready0), .sout(sout0), .busy(busy0), .stuff(stuff0),
    .dbg_state(dbg0)
  );

  int checks = 0;
  int errors = 0;

  // Expected line cycles: {sout, stuff, tx_ready}.
  logic [2:0] exp_q[$];

  // Receive-side 1010 non-overlapping detector reference.
  logic [3:0] det_sh;
  int         det_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the frame from the framing rules, stuffing on the emitted stream itself.
  task automatic model_frame(input logic [W-1:0] d, input bit en);
    logic [3:0] sw;
    sw = 4'b1010;
    for (int i = 3; i >= 0; i--) exp_q.push_back({sw[i], 2'b00});
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back({d[i], 2'b00});
      if (i != 0 && en && exp_q[$-2][2] && !exp_q[$-1][2] && exp_q[$][2])
        exp_q.push_back(3'b110);
    end
    exp_q.push_back(3'b101);
  endtask

  task automatic det_step(input logic b, output logic y);
    det_sh = {det_sh[2:0], b};
    det_len++;
    y = 1'b0;
    if (det_len >= 4 && det_sh == 4'b1010) begin
      y = 1'b1;
      det_len = 0;
    end
  endtask

  // Walk the expected queue one line cycle per negedge.
  task automatic run_frames(input int drop_at, input logic [W-1:0] next_data, input bit use_det);
    int idx, ycnt, ypos;
    logic [2:0] e;
    logic y;
    idx = 0; ycnt = 0; ypos = -1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (idx == 0) tx_data = next_data;
      if (idx == drop_at) tb_valid = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("sout[%0d]", idx), o_sout, e[2]);
      chk($sformatf("stuff[%0d]", idx), o_stuff, e[1]);
      chk($sformatf("ready[%0d]", idx), o_ready, e[0]);
      chk($sformatf("busy[%0d]", idx), o_busy, 1);
      if (use_det) begin
        det_step(o_sout, y);
        if (y) begin
          ycnt++;
          ypos = idx;
        end
      end
      idx++;
    end
    if (use_det) begin
      chk("det_pulses", ycnt, 1);
      chk("det_pos", ypos, 3);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit en, input bit use_det);
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_sout", o_sout, 1);
    chk("idle_ready", o_ready, 1);
    tx_data  = d;
    tb_valid = 1'b1;
    model_frame(d, en);
    @(posedge clk);
    run_frames(0, d, use_det);
  endtask

  initial begin
    int gap;
    rst = 1'b1; tb_valid = 1'b0; use1 = 1'b1; tx_data = '0;
    det_sh = 4'b0; det_len = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_sout1", sout1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_ready1", ready1, 1);
    chk("rst_stuff1", stuff1, 0);
    chk("rst_sout0", sout0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", ready0, 1);

    // Mid-frame reset held three cycles.
    @(negedge clk);
    tx_data = 8'hA5; tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    chk("pre_rst_busy", o_busy, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("post_rst_sout", o_sout, 1);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_stuff", o_stuff, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("residual_sout[%0d]", i), o_sout, 1);
      chk($sformatf("residual_busy[%0d]", i), o_busy, 0);
    end

    // Reset wins over a simultaneous accept.
    rst = 1'b1; tb_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    rst = 1'b0; tb_valid = 1'b0;
    chk("rst_prio_busy", o_busy, 0);
    chk("rst_prio_sout", o_sout, 1);

    // Directed frames with stuffing.
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);

    // No stuffing instance.
    use1 = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    use1 = 1'b1;

    // Back-to-back: valid held across two words, second accepted in STOP.
    @(negedge clk);
    chk("b2b_idle_ready", o_ready, 1);
    tx_data = 8'h0F; tb_valid = 1'b1;
    model_frame(8'h0F, 1'b1);
    gap = exp_q.size();
    model_frame(8'hF0, 1'b1);
    @(posedge clk);
    run_frames(gap, 8'hF0, 1'b0);
    @(negedge clk);
    chk("b2b_end_busy", o_busy, 0);
    chk("b2b_end_sout", o_sout, 1);

    // Random words through the loopback detector model.
    det_sh = 4'b0; det_len = 0;
    for (int n = 0; n < 100; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      send_frame(W'($urandom), 1'b1, 1'b1);
    end
    use1 = 1'b0;
    for (int n = 0; n < 20; n++) send_frame(W'($urandom), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
